timer_dev: RTL and testbench
============================

# timer_dev

Programmable 32-bit down-counting timer on the CPU's device bus. Its `IRQ` output feeds one bit of the `HWInt[5:0]` vector consumed by the CP0 register block, which then raises `IntReq`. Software programs the timer with SW/LW through a 3-register window. It supports one-shot and auto-reload modes.

## Interface
No parameters.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-low (0 = reset), sampled on rising edge of `clk`
- `Addr`  in  2  word address within device window: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- `We`  in  1  bus write strobe, one cycle per write
- `DIn`  in  32  bus write data
- `DOut`  out  32  bus read data, combinational from `Addr`
- `IRQ`  out  1  interrupt request to CP0 `HWInt`, registered

## Operation
- **CTRL** (R/W):
  - [3] IM, interrupt mask: 1 = enabled.
  - [2:1] Mode: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0.
  - [0] Enable.
  - Bits [31:4] read 0.
- **PRESET** (R/W, 32 bit): reload value. Value 0 is treated as 1.
- **COUNT** (read-only): current counter. Writes to it are ignored.
- **Reserved** (Addr 3): reads 0; writes are ignored.
- **Reads:** `DOut` = {28'b0, IM, Mode, Enable}, PRESET, COUNT, or 0, selected by `Addr`.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if Enable = 1 → LOAD; else stay.
  - LOAD: COUNT ← PRESET → CNT.
  - CNT:
    - if Enable = 0 → IDLE, COUNT holds;
    - else if COUNT > 1 → COUNT−1, stay;
    - else COUNT ← 0, irq_pend ← 1 → INT.
  - INT, Mode 0: Enable ← 0 → IDLE. irq_pend stays 1.
  - INT, Mode 1: irq_pend ← 0. Next state is LOAD if Enable = 1, else IDLE.
- **irq_pend clearing:** cleared by any bus write to CTRL or PRESET, and by the Mode 1 INT exit.
- **IRQ output:** `IRQ` = irq_pend & IM, registered.
- **Simultaneous events:**
  - A CTRL write in the same cycle as the Mode 0 INT auto-clear of Enable: the bus write wins, so CTRL takes DIn.
  - A CTRL write in the same cycle irq_pend would be set: clear wins.
- **PRESET write while counting:** does not disturb COUNT; it takes effect at the next LOAD.
- **Disabling mid-count:** writing Enable = 0 during CNT freezes COUNT. Re-enabling goes through IDLE → LOAD, so the count restarts from PRESET rather than resuming.

## Timing
- **Reset** (`rst` = 0 at an edge): CTRL = 0, PRESET = 0, COUNT = 0, irq_pend = 0, state = IDLE, `IRQ` = 0. `DOut` is therefore 0 for every `Addr`.
- **Reset mid-operation:** reset in any state overrides everything. `IRQ` drops at that edge.
- **Edge numbering:** e0 is the edge that writes Enable = 1 with PRESET = P ≥ 1.
  - e1: IDLE → LOAD.
  - e2: COUNT = P, state CNT.
  - COUNT reaches 1 after e(P+1).
  - e(P+2): COUNT = 0, state INT, irq_pend = 1.
  - `IRQ` is high (if IM = 1) from e(P+2) onward.
- **Mode 0:** `IRQ` stays high until a CTRL/PRESET write or reset. Enable reads 0 after e(P+3).
- **Mode 1:** `IRQ` is a one-cycle pulse, high between e(P+2) and e(P+3). The period is P+2 cycles: LOAD, then P cycles in CNT, then INT.
- **Writes:** a bus write is visible on `DOut` in the cycle after its edge.
- **Latencies:** read latency is 0 cycles. IRQ-to-HWInt is 0 cycles; CP0 samples it on its own next edge.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles, then read Addr 0/1/2/3. Expect all reads 0 and `IRQ` = 0.
- **One-shot:**
  - Stimulus: write PRESET = 5, then CTRL = 0x9 (IM = 1, Mode 0, Enable).
  - Expect `IRQ` rising exactly 7 edges after the CTRL write edge, and COUNT reading 5, 4, 3, 2, 1, 0 on successive cycles.
  - Expect CTRL to read 0x8 afterwards, and `IRQ` to stay high until a CTRL write of 0x8 clears it the next cycle.
- **Auto-reload:**
  - Stimulus: PRESET = 3, CTRL = 0xB.
  - Expect one-cycle `IRQ` pulses every 5 cycles, first pulse 5 edges after the write, over at least 4 periods.
- **Mask:**
  - Stimulus: PRESET = 2, CTRL = 0x1 (IM = 0).
  - Expect `IRQ` never high, while the FSM completes and CTRL reads 0x0.
  - Then write CTRL = 0x8: expect `IRQ` to stay 0, because the write cleared irq_pend.
- **Disable mid-count:**
  - Stimulus: PRESET = 10, CTRL = 0x9; at COUNT = 6 write CTRL = 0x8.
  - Expect COUNT frozen at ≤ 6 and no `IRQ`.
  - Re-enable: expect COUNT reloaded to 10, and PRESET = 0 behaving as 1 on a follow-up run.
- **Collisions:**
  - Stimulus: in Mode 0, write CTRL = 0x9 on the exact edge the FSM leaves INT.
  - Expect Enable = 1 retained and a new count from PRESET.
  - Assert `rst` = 0 during CNT: `IRQ` = 0 and all registers 0 on the next cycle.

Source files
------------

// File: rtl/timer_dev_if.sv
// Device-bus window of the timer: word address, write strobe/data, read data and IRQ.
// The CPU side drives through master; the timer attaches as slave.
interface timer_dev_if;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (output Addr, output We, output DIn, input DOut, input IRQ);
  modport slave  (input Addr, input We, input DIn, output DOut, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// 32-bit down-counting timer with one-shot/auto-reload modes behind a 3-register bus window.
// Reads are combinational from Addr; IRQ is registered and follows the next-state pending flag.
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        im;
  logic [1:0]  mode;
  logic        en;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;
  logic        irq;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        pend_set;
  logic        pend_clr;
  logic        pend_nxt;
  logic        im_nxt;
  logic [31:0] rd_dat;

  assign wr_ctrl   = bus.We && (bus.Addr == 2'd0);
  assign wr_preset = bus.We && (bus.Addr == 2'd1);

  // Any CTRL/PRESET write beats a pending set in the same cycle.
  always_comb begin
    pend_set = (state == CNT) && en && (count <= 32'd1);
    pend_clr = wr_ctrl || wr_preset || ((state == INT) && (mode == 2'd1));
    pend_nxt = irq_pend;
    if (pend_clr)
      pend_nxt = 1'b0;
    else if (pend_set)
      pend_nxt = 1'b1;
    im_nxt = wr_ctrl ? bus.DIn[3] : im;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      im       <= 1'b0;
      mode     <= 2'd0;
      en       <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= pend_nxt;
      irq      <= pend_nxt & im_nxt;
      if (wr_ctrl)
        {im, mode, en} <= bus.DIn[3:0];
      if (wr_preset)
        preset <= bus.DIn;
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= (preset == 32'd0) ? 32'd1 : preset;
          state <= CNT;
        end
        CNT: begin
          if (!en)
            state <= IDLE;
          else if (count > 32'd1)
            count <= count - 32'd1;
          else begin
            count <= 32'd0;
            state <= INT;
          end
        end
        INT: begin
          if (mode == 2'd1)
            state <= en ? LOAD : IDLE;
          else begin
            state <= IDLE;
            // A simultaneous bus write to CTRL keeps the written Enable.
            if (!wr_ctrl)
              en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (bus.Addr)
      2'd0:    rd_dat = {28'd0, im, mode, en};
      2'd1:    rd_dat = preset;
      2'd2:    rd_dat = count;
      default: rd_dat = 32'd0;
    endcase
  end

  assign bus.DOut = rd_dat;
  assign bus.IRQ  = irq;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, mask, disable, collisions.
module tb_timer_dev;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] d;

  timer_dev_if bus();

  timer_dev dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.Addr = a;
    bus.DIn  = v;
    bus.We   = 1'b1;
    tick();
    bus.We   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.Addr = a;
    #1;
    v = bus.DOut;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.We = 1'b0;
    bus.Addr = 2'd0;
    bus.DIn = 32'd0;

    // Reset
    tick();
    tick();
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      chk($sformatf("reset_rd%0d", a), d, 32'd0);
    end
    chk("reset_irq", {31'd0, bus.IRQ}, 32'd0);

    // One-shot, P=5: COUNT 5..0 after e2..e7, IRQ rises at e7
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick();
    chk("os_irq_e1", {31'd0, bus.IRQ}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(2'd2, d);
      chk($sformatf("os_count_e%0d", i + 2), d, 32'd5 - i);
      chk($sformatf("os_irq_e%0d", i + 2), {31'd0, bus.IRQ}, (i == 5) ? 32'd1 : 32'd0);
    end
    tick();
    rd(2'd0, d);
    chk("os_ctrl_after", d, 32'h8);
    tick();
    tick();
    chk("os_irq_held", {31'd0, bus.IRQ}, 32'd1);
    wr(2'd0, 32'h8);
    chk("os_irq_cleared", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, P=3: pulses at e5, e10, e15, e20
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk($sformatf("ar_irq_e%0d", k), {31'd0, bus.IRQ},
          ((k >= 5) && ((k - 5) % 5 == 0)) ? 32'd1 : 32'd0);
    end
    wr(2'd0, 32'h0);
    tick();
    tick();

    // Reserved window and PRESET readback
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d);
    chk("rsv_read", d, 32'd0);
    rd(2'd1, d);
    chk("preset_read", d, 32'd3);

    // Mask: IM=0, P=2, run completes with no IRQ
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("mask_irq_e%0d", k), {31'd0, bus.IRQ}, 32'd0);
    end
    rd(2'd0, d);
    chk("mask_ctrl", d, 32'h0);
    wr(2'd0, 32'h8);
    chk("mask_irq_after_im", {31'd0, bus.IRQ}, 32'd0);
    tick();
    chk("mask_irq_after_im2", {31'd0, bus.IRQ}, 32'd0);

    // Disable mid-count, P=10
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) tick();
    rd(2'd2, d);
    chk("dis_count6", d, 32'd6);
    wr(2'd0, 32'h8);
    tick();
    tick();
    tick();
    rd(2'd2, d);
    chk("dis_frozen", d, 32'd5);
    chk("dis_irq", {31'd0, bus.IRQ}, 32'd0);

    // Re-enable reloads from PRESET; PRESET write mid-count leaves COUNT alone
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, d);
    chk("reen_count", d, 32'd10);
    wr(2'd1, 32'd0);
    rd(2'd2, d);
    chk("preset_wr_midcount", d, 32'd9);
    for (int k = 4; k <= 13; k++) tick();
    chk("reen_irq", {31'd0, bus.IRQ}, 32'd1);
    rd(2'd0, d);
    chk("reen_ctrl", d, 32'h8);

    // PRESET=0 behaves as 1: IRQ at e3
    wr(2'd0, 32'h9);
    chk("p0_irq_clr", {31'd0, bus.IRQ}, 32'd0);
    tick();
    tick();
    rd(2'd2, d);
    chk("p0_count", d, 32'd1);
    chk("p0_irq_e2", {31'd0, bus.IRQ}, 32'd0);
    tick();
    rd(2'd2, d);
    chk("p0_count_e3", d, 32'd0);
    chk("p0_irq_e3", {31'd0, bus.IRQ}, 32'd1);

    // Collision: CTRL write on the edge the FSM leaves INT
    wr(2'd0, 32'h9);
    rd(2'd0, d);
    chk("col_ctrl", d, 32'h9);
    chk("col_irq", {31'd0, bus.IRQ}, 32'd0);
    wr(2'd1, 32'd4);
    tick();
    rd(2'd2, d);
    chk("col_count", d, 32'd4);
    tick();
    rd(2'd2, d);
    chk("col_count2", d, 32'd3);

    // Reset during CNT
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      chk($sformatf("rst_rd%0d", a), d, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
